// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: boot-gated PC sequencer feeding a tagged prefetch FIFO with redirect flush and fetch trap
module instr_fetch_ctrl #(
  parameter int          MEM_BYTES   = 32,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          BOOT_CYCLES = 2,
  parameter int          FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  output logic        mem_reset,
  input  logic [31:0] Instruction_Code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);
  typedef enum logic [1:0] {BOOT, FETCH, ERROR} state_e;
  state_e        state_q, state_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q [FIFO_DEPTH];
  logic          pop, push, flush, bad_pc;
  assign bad_pc    = redirect_pc[1:0] != 2'b00 || redirect_pc > LAST_PC;
  assign out_valid = cnt_q != '0;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? fifo_instr_q[rd_q] : '0;
  assign out_pc    = out_valid ? fifo_pc_q[rd_q] : '0;
  assign mem_reset = state_q == BOOT;
  assign fetch_err = err_q;
  assign PC        = pc_q;
  assign rd_d      = flush ? '0 : rd_q + AW'(pop);
  assign wr_d      = flush ? '0 : wr_q + AW'(push);
  assign cnt_d     = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  // next state: boot countdown, fetch/push decision, redirect flush and illegal-target trap
  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    pc_d    = pc_q;
    err_d   = err_q;
    flush   = 1'b0;
    push    = 1'b0;
    if (state_q == BOOT) begin
      boot_d  = boot_q + BW'(1);
      state_d = boot_q == BW'(BOOT_CYCLES - 1) ? FETCH : BOOT;
    end else if (state_q == FETCH) begin
      if (redirect_valid) begin
        flush   = 1'b1;
        state_d = bad_pc ? ERROR : FETCH;
        err_d   = bad_pc;
        pc_d    = bad_pc ? pc_q : redirect_pc;
      end else begin
        push = !cnt_q[AW] || pop;
        pc_d = !push ? pc_q : pc_q == LAST_PC ? '0 : pc_q + 32'd4;
      end
    end
  end
  // control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      boot_q  <= '0;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  // FIFO storage; contents are only visible through a nonzero count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_q] <= Instruction_Code;
      fifo_pc_q[wr_q]    <= pc_q;
    end
  end
endmodule
